// File: rtl/button_event_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : button_event_ctrl                                            |
// | Description : Debounces N active-low pushbuttons into press/release pulses |
// |               and shares one hold timer between them to generate           |
// |               long-press and auto-repeat pulses for setpoint stepping.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module button_event_ctrl #(
  parameter int N_BTN = 4,
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [N_BTN-1:0] i_btn,
  input  logic [CNT_W-1:0] i_debounce_limit,
  input  logic [CNT_W-1:0] i_long_limit,
  input  logic [CNT_W-1:0] i_repeat_period,
  output logic [N_BTN-1:0] o_level,
  output logic [N_BTN-1:0] o_press,
  output logic [N_BTN-1:0] o_release,
  output logic [N_BTN-1:0] o_long,
  output logic [N_BTN-1:0] o_repeat,
  output logic             o_busy,
  output logic [2:0]       o_owner
);

  localparam logic [1:0] C_IDLE   = 2'd0;
  localparam logic [1:0] C_HOLD   = 2'd1;
  localparam logic [1:0] C_REPEAT = 2'd2;

  localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Per-button registered results gathered into vectors
  logic [N_BTN-1:0] level_vec_q;
  logic [N_BTN-1:0] press_vec_q;
  logic [N_BTN-1:0] release_vec_q;

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_btn
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             level_q, level_d;
      logic             press_q, press_d;
      logic             release_q, release_d;

      // Count consecutive mismatched edges; flip once the count has reached the limit
      always_comb begin
        cnt_d     = '0;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (i_btn[gi] != level_q) begin
          if (cnt_q >= i_debounce_limit) begin
            // >= so a limit lowered mid-count flips at once instead of wrapping
            level_d   = i_btn[gi];
            press_d   = ~i_btn[gi];
            release_d = i_btn[gi];
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + C_ONE;
          end else begin
            cnt_d = cnt_q;
          end
        end
      end

      // Debounce counter, debounced level and edge pulses
      always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
          cnt_q     <= '0;
          level_q   <= 1'b1;
          press_q   <= 1'b0;
          release_q <= 1'b0;
        end else begin
          cnt_q     <= cnt_d;
          level_q   <= level_d;
          press_q   <= press_d;
          release_q <= release_d;
        end
      end

      assign level_vec_q[gi]   = level_q;
      assign press_vec_q[gi]   = press_q;
      assign release_vec_q[gi] = release_q;
    end
  endgenerate

  // Shared hold-timer FSM
  logic [1:0]       state_q, state_d;
  logic [2:0]       owner_q, owner_d;
  logic [CNT_W-1:0] t_q, t_d;
  logic [N_BTN-1:0] long_q, long_d;
  logic [N_BTN-1:0] repeat_q, repeat_d;
  logic             busy_q, busy_d;

  logic [2:0]       grant_idx;
  logic [N_BTN-1:0] grant_oh;
  logic [N_BTN-1:0] owner_oh;
  logic             any_press;
  logic             owner_released;
  logic             long_en;
  logic             rep_en;
  logic             long_now;
  logic             long_due;
  logic             rep_due;
  logic [CNT_W-1:0] t_inc;
  logic [CNT_W+1:0] t_plus2;
  logic [CNT_W:0]   t_plus1;

  // Lowest-index press wins the timer; decode the grant and current owner one-hot
  always_comb begin
    grant_idx = 3'd0;
    grant_oh  = '0;
    owner_oh  = '0;
    for (int k = N_BTN - 1; k >= 0; k--) begin
      if (press_vec_q[k]) begin
        grant_idx = 3'(k);
      end
    end
    for (int k = 0; k < N_BTN; k++) begin
      grant_oh[k] = press_vec_q[k] && (grant_idx == 3'(k));
      owner_oh[k] = (owner_q == 3'(k));
    end
  end

  assign any_press      = |press_vec_q;
  assign owner_released = |(owner_oh & level_vec_q);
  assign long_en        = (i_long_limit != '0);
  assign rep_en         = (i_repeat_period != '0);
  assign long_now       = (i_long_limit == C_ONE);
  assign t_inc          = (t_q == '1) ? t_q : t_q + C_ONE;
  // Timer starts at 0 the cycle after the press, so the long pulse is due when T+2 reaches L_L
  assign t_plus2        = {2'b00, t_q} + {{CNT_W{1'b0}}, 2'b10};
  assign long_due       = t_plus2 >= {2'b00, i_long_limit};
  // Repeat timer starts at 0 in the long-pulse cycle, so a repeat is due when T+1 reaches R
  assign t_plus1        = {1'b0, t_q} + {{CNT_W{1'b0}}, 1'b1};
  assign rep_due        = t_plus1 >= {1'b0, i_repeat_period};

  // State register with the timer datapath and registered event outputs
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= C_IDLE;
      owner_q  <= 3'd0;
      t_q      <= '0;
      long_q   <= '0;
      repeat_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      t_q      <= t_d;
      long_q   <= long_d;
      repeat_q <= repeat_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state: grant on press, abort on owner release or long-press disable
  always_comb begin
    state_d = state_q;
    case (state_q)
      C_IDLE: begin
        if (long_en && any_press) begin
          // A limit of 1 means the long pulse lands in the very next cycle
          state_d = long_now ? C_REPEAT : C_HOLD;
        end
      end
      C_HOLD: begin
        if (!long_en || owner_released) begin
          state_d = C_IDLE;
        end else if (long_due) begin
          state_d = C_REPEAT;
        end
      end
      C_REPEAT: begin
        if (!long_en || owner_released) begin
          state_d = C_IDLE;
        end
      end
      default: state_d = C_IDLE;
    endcase
  end

  // Outputs: owner capture, timer update and long/repeat pulses for the owner only
  always_comb begin
    owner_d  = owner_q;
    t_d      = t_q;
    long_d   = '0;
    repeat_d = '0;
    busy_d   = (state_d != C_IDLE);
    case (state_q)
      C_IDLE: begin
        if (long_en && any_press) begin
          owner_d = grant_idx;
          t_d     = '0;
          if (long_now) begin
            long_d = grant_oh;
          end
        end
      end
      C_HOLD: begin
        if (!long_en || owner_released) begin
          t_d = '0;
        end else if (long_due) begin
          long_d = owner_oh;
          t_d    = '0;
        end else begin
          t_d = t_inc;
        end
      end
      C_REPEAT: begin
        if (!long_en || owner_released) begin
          // Release beats a repeat due in the same cycle
          t_d = '0;
        end else if (rep_en && rep_due) begin
          repeat_d = owner_oh;
          t_d      = '0;
        end else begin
          t_d = t_inc;
        end
      end
      default: t_d = '0;
    endcase
  end

  assign o_level   = level_vec_q;
  assign o_press   = press_vec_q;
  assign o_release = release_vec_q;
  assign o_long    = long_q;
  assign o_repeat  = repeat_q;
  assign o_busy    = busy_q;
  assign o_owner   = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_button_event_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_button_event_ctrl                                         |
// | Description : Directed self-checking bench for button_event_ctrl           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_button_event_ctrl;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic [3:0]  i_btn = 4'hF;
  logic [31:0] i_debounce_limit = 32'd0;
  logic [31:0] i_long_limit = 32'd0;
  logic [31:0] i_repeat_period = 32'd0;
  logic [3:0]  o_level, o_press, o_release, o_long, o_repeat;
  logic        o_busy;
  logic [2:0]  o_owner;

  int checks = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  button_event_ctrl #(.N_BTN(4), .CNT_W(32)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_btn(i_btn),
    .i_debounce_limit(i_debounce_limit), .i_long_limit(i_long_limit),
    .i_repeat_period(i_repeat_period), .o_level(o_level), .o_press(o_press),
    .o_release(o_release), .o_long(o_long), .o_repeat(o_repeat),
    .o_busy(o_busy), .o_owner(o_owner)
  );

  task automatic settle(input int n);
    i_btn = 4'hF;
    repeat (n) @(negedge i_clk);
  endtask

  task automatic test_reset();
    logic [3:0] exp_level, exp_press;
    i_reset = 1'b0; i_btn = 4'h0; i_debounce_limit = 32'd3;
    i_long_limit = 32'd0; i_repeat_period = 32'd0;
    repeat (3) @(negedge i_clk);
    checks++; if (o_level !== 4'hF) begin failures++; $display("FAIL reset_level got=%h exp=f", o_level); end
    checks++; if ({o_press, o_release, o_long, o_repeat} !== 16'h0) begin failures++; $display("FAIL reset_pulses got=%h exp=0", {o_press, o_release, o_long, o_repeat}); end
    checks++; if (o_busy !== 1'b0 || o_owner !== 3'd0) begin failures++; $display("FAIL reset_busy_owner got=%b/%0d exp=0/0", o_busy, o_owner); end
    i_reset = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge i_clk);
      exp_level = (i >= 4) ? 4'h0 : 4'hF;
      exp_press = (i == 4) ? 4'hF : 4'h0;
      checks++; if (o_level !== exp_level) begin failures++; $display("FAIL deb_level edge=%0d got=%h exp=%h", i, o_level, exp_level); end
      checks++; if (o_press !== exp_press) begin failures++; $display("FAIL deb_press edge=%0d got=%h exp=%h", i, o_press, exp_press); end
    end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL disabled_busy got=%b exp=0", o_busy); end
    settle(6);
  endtask

  task automatic test_glitch();
    logic [3:0] glitch_press;
    int press_at, npress, release_at;
    i_debounce_limit = 32'd5; i_long_limit = 32'd0;
    glitch_press = 4'h0; press_at = -1; npress = 0; release_at = -1;
    i_btn[1] = 1'b0;
    repeat (5) begin @(negedge i_clk); glitch_press |= o_press; end
    i_btn[1] = 1'b1;
    @(negedge i_clk); glitch_press |= o_press;
    checks++; if (glitch_press !== 4'h0 || o_level !== 4'hF) begin failures++; $display("FAIL glitch_reject press=%h level=%h exp=0/f", glitch_press, o_level); end
    i_btn[1] = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge i_clk);
      if (o_press != 4'h0) begin npress++; press_at = i; end
    end
    checks++; if (npress != 1 || press_at != 6) begin failures++; $display("FAIL glitch_press6 count=%0d at=%0d exp=1/6", npress, press_at); end
    checks++; if (o_level !== 4'b1101) begin failures++; $display("FAIL glitch_level got=%h exp=d", o_level); end
    i_btn[1] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge i_clk);
      if (o_release[1]) release_at = i;
    end
    checks++; if (release_at != 6) begin failures++; $display("FAIL glitch_release at=%0d exp=6", release_at); end
  endtask

  task automatic test_long_repeat();
    int t, nlong, long_at, nrep, rep_first, rep_last, rep_bad, release_at;
    logic busy_t1, busy_63, busy_64, bad_bits;
    logic [2:0] owner_t1;
    t = -1; nlong = 0; long_at = -1; nrep = 0; rep_first = -1; rep_last = -1;
    rep_bad = 0; release_at = -1; busy_t1 = 0; busy_63 = 0; busy_64 = 1; bad_bits = 0; owner_t1 = 3'd7;
    i_debounce_limit = 32'd2; i_long_limit = 32'd20; i_repeat_period = 32'd8;
    i_btn[2] = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge i_clk);
      if (t < 0 && o_press[2]) t = i;
      if (o_long != 4'h0) begin nlong++; long_at = i; if (o_long !== 4'b0100) bad_bits = 1; end
      if (o_repeat != 4'h0) begin
        nrep++; if (rep_first < 0) rep_first = i; rep_last = i;
        if (o_repeat !== 4'b0100) bad_bits = 1;
        if (t < 0 || ((i - t - 20) % 8) != 0) rep_bad++;
      end
      if (o_release[2]) release_at = i;
      if (t >= 0 && i == t + 1) begin busy_t1 = o_busy; owner_t1 = o_owner; end
      if (t >= 0 && i == t + 63) busy_63 = o_busy;
      if (t >= 0 && i == t + 64) busy_64 = o_busy;
      if (t >= 0 && i == t + 60) i_btn[2] = 1'b1;
    end
    checks++; if (t != 3) begin failures++; $display("FAIL lr_press_at got=%0d exp=3", t); end
    checks++; if (busy_t1 !== 1'b1 || owner_t1 !== 3'd2) begin failures++; $display("FAIL lr_grant busy=%b owner=%0d exp=1/2", busy_t1, owner_t1); end
    checks++; if (nlong != 1 || long_at != t + 20) begin failures++; $display("FAIL lr_long count=%0d at=%0d exp=1/%0d", nlong, long_at, t + 20); end
    checks++; if (nrep != 5 || rep_first != t + 28 || rep_last != t + 60 || rep_bad != 0) begin failures++; $display("FAIL lr_repeat count=%0d first=%0d last=%0d bad=%0d exp=5/%0d/%0d/0", nrep, rep_first, rep_last, rep_bad, t + 28, t + 60); end
    checks++; if (bad_bits !== 1'b0) begin failures++; $display("FAIL lr_owner_only got=%b exp=0", bad_bits); end
    checks++; if (release_at != t + 63) begin failures++; $display("FAIL lr_release at=%0d exp=%0d", release_at, t + 63); end
    checks++; if (busy_63 !== 1'b1 || busy_64 !== 1'b0) begin failures++; $display("FAIL lr_idle busy63=%b busy64=%b exp=1/0", busy_63, busy_64); end
  endtask

  task automatic test_short_press();
    int t, nlong, release_at;
    logic busy_19, busy_20;
    t = -1; nlong = 0; release_at = -1; busy_19 = 0; busy_20 = 1;
    i_debounce_limit = 32'd2; i_long_limit = 32'd20; i_repeat_period = 32'd8;
    i_btn[0] = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge i_clk);
      if (t < 0 && o_press[0]) t = i;
      if ((o_long | o_repeat) != 4'h0) nlong++;
      if (o_release[0]) release_at = i;
      if (t >= 0 && i == t + 19) busy_19 = o_busy;
      if (t >= 0 && i == t + 20) busy_20 = o_busy;
      if (t >= 0 && i == t + 16) i_btn[0] = 1'b1;
    end
    checks++; if (t < 0 || nlong != 0) begin failures++; $display("FAIL short_no_long t=%0d pulses=%0d exp=0", t, nlong); end
    checks++; if (release_at != t + 19) begin failures++; $display("FAIL short_release at=%0d exp=%0d", release_at, t + 19); end
    checks++; if (busy_19 !== 1'b1 || busy_20 !== 1'b0) begin failures++; $display("FAIL short_busy b19=%b b20=%b exp=1/0", busy_19, busy_20); end
  endtask

  task automatic test_arbitration();
    int t, press2_at, nlong, long_at, nrep;
    logic [3:0] first_press, second_press, long_val;
    logic [2:0] owner_t1, owner_t6;
    logic busy_28, busy_30;
    t = -1; press2_at = -1; nlong = 0; long_at = -1; nrep = 0;
    first_press = 4'h0; second_press = 4'h0; long_val = 4'h0;
    owner_t1 = 3'd7; owner_t6 = 3'd7; busy_28 = 0; busy_30 = 1;
    i_debounce_limit = 32'd2; i_long_limit = 32'd10; i_repeat_period = 32'd0;
    i_btn = 4'b0101;
    for (int i = 1; i <= 40; i++) begin
      @(negedge i_clk);
      if (t >= 0 && i > t && o_press != 4'h0) begin second_press = o_press; press2_at = i; end
      if (t < 0 && o_press != 4'h0) begin t = i; first_press = o_press; end
      if (o_long != 4'h0) begin nlong++; long_at = i; long_val = o_long; end
      if (o_repeat != 4'h0) nrep++;
      if (t >= 0 && i == t + 1) owner_t1 = o_owner;
      if (t >= 0 && i == t + 6) owner_t6 = o_owner;
      if (t >= 0 && i == t + 28) busy_28 = o_busy;
      if (t >= 0 && i == t + 30) busy_30 = o_busy;
      if (t >= 0 && i == t + 2) i_btn[0] = 1'b0;
      if (t >= 0 && i == t + 25) i_btn = 4'hF;
    end
    checks++; if (t != 3 || first_press !== 4'b1010) begin failures++; $display("FAIL arb_press at=%0d got=%h exp=3/a", t, first_press); end
    checks++; if (owner_t1 !== 3'd1) begin failures++; $display("FAIL arb_owner got=%0d exp=1", owner_t1); end
    checks++; if (press2_at != t + 5 || second_press !== 4'b0001 || owner_t6 !== 3'd1) begin failures++; $display("FAIL arb_busy_press at=%0d got=%h owner=%0d exp=%0d/1/1", press2_at, second_press, owner_t6, t + 5); end
    checks++; if (nlong != 1 || long_at != t + 10 || long_val !== 4'b0010) begin failures++; $display("FAIL arb_long count=%0d at=%0d val=%h exp=1/%0d/2", nlong, long_at, long_val, t + 10); end
    checks++; if (nrep != 0) begin failures++; $display("FAIL arb_r0_repeat count=%0d exp=0", nrep); end
    checks++; if (busy_28 !== 1'b1 || busy_30 !== 1'b0) begin failures++; $display("FAIL arb_idle b28=%b b30=%b exp=1/0", busy_28, busy_30); end
  endtask

  task automatic test_disable_midchange();
    int t, nbusy, npulse, nrep, rep_first, rep_last;
    logic busy_3, busy_4, busy_pre, lvl3_pre;
    nbusy = 0; npulse = 0;
    i_debounce_limit = 32'd2; i_long_limit = 32'd0; i_repeat_period = 32'd5;
    i_btn[0] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge i_clk);
      if (o_busy) nbusy++;
      if ((o_long | o_repeat) != 4'h0) npulse++;
    end
    checks++; if (o_level[0] !== 1'b0 || nbusy != 0 || npulse != 0) begin failures++; $display("FAIL dis_never_busy level0=%b busy=%0d pulses=%0d exp=0/0/0", o_level[0], nbusy, npulse); end
    settle(5);

    t = -1; busy_3 = 0; busy_4 = 1;
    i_long_limit = 32'd10; i_btn[1] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge i_clk);
      if (t < 0 && o_press[1]) t = i;
      if (t >= 0 && i == t + 3) begin busy_3 = o_busy; i_long_limit = 32'd0; end
      if (t >= 0 && i == t + 4) busy_4 = o_busy;
    end
    checks++; if (busy_3 !== 1'b1 || busy_4 !== 1'b0) begin failures++; $display("FAIL dis_midhold b3=%b b4=%b exp=1/0", busy_3, busy_4); end
    settle(5);

    t = -1; nrep = 0; rep_first = -1; rep_last = -1; busy_pre = 0; lvl3_pre = 1;
    i_long_limit = 32'd10; i_repeat_period = 32'd5; i_btn[3] = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge i_clk);
      if (t < 0 && o_press[3]) t = i;
      if (o_repeat[3]) begin nrep++; if (rep_first < 0) rep_first = i; rep_last = i; end
      if (t >= 0 && i == t + 20) i_repeat_period = 32'd0;
      if (t >= 0 && i == t + 40) begin busy_pre = o_busy; lvl3_pre = o_level[3]; break; end
    end
    checks++; if (nrep != 2 || rep_first != t + 15 || rep_last != t + 20) begin failures++; $display("FAIL mid_r0 count=%0d first=%0d last=%0d exp=2/%0d/%0d", nrep, rep_first, rep_last, t + 15, t + 20); end
    checks++; if (busy_pre !== 1'b1 || lvl3_pre !== 1'b0) begin failures++; $display("FAIL mid_prereset busy=%b lvl3=%b exp=1/0", busy_pre, lvl3_pre); end
    i_reset = 1'b0;
    #1;
    checks++; if (o_level !== 4'hF || o_busy !== 1'b0 || o_owner !== 3'd0) begin failures++; $display("FAIL async_reset level=%h busy=%b owner=%0d exp=f/0/0", o_level, o_busy, o_owner); end
    checks++; if ({o_press, o_release, o_long, o_repeat} !== 16'h0) begin failures++; $display("FAIL async_reset_pulses got=%h exp=0", {o_press, o_release, o_long, o_repeat}); end
    i_btn = 4'hF;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b1;
    nbusy = 0; npulse = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge i_clk);
      if (o_busy) nbusy++;
      if ({o_press, o_release, o_long, o_repeat} != 16'h0) npulse++;
    end
    checks++; if (o_level !== 4'hF || nbusy != 0 || npulse != 0) begin failures++; $display("FAIL post_reset level=%h busy=%0d pulses=%0d exp=f/0/0", o_level, nbusy, npulse); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_glitch();
    test_long_repeat();
    test_short_press();
    test_arbitration();
    test_disable_midchange();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/button_event_ctrl.md
Name: button_event_ctrl

Overview:
Multi-button front-end controller for the operator pushbuttons of the hybrid-control board. It debounces N raw active-low buttons with a runtime-configurable limit and turns them into one-cycle press/release events. One shared hold timer is arbitrated between the buttons to produce long-press and auto-repeat events, which drive setpoint up/down stepping. Sits between the board button pins (after 2-FF synchronisers, external) and the parameter/mode logic.

Parameters:
N_BTN, 4, number of buttons (1..8)
CNT_W, 32, width of all counters and of the limit/period inputs

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous, active-low reset
i_btn  in  N_BTN  synchronised raw buttons; 1 = released, 0 = pressed
i_debounce_limit  in  CNT_W  debounce length L_D (cycles)
i_long_limit  in  CNT_W  long-press time L_L (cycles); 0 = long/repeat disabled
i_repeat_period  in  CNT_W  auto-repeat period R (cycles); 0 = repeat disabled
o_level  out  N_BTN  debounced level per button; 1 = released
o_press  out  N_BTN  one-cycle pulse on debounced 1->0
o_release  out  N_BTN  one-cycle pulse on debounced 0->1
o_long  out  N_BTN  one-cycle long-press pulse, owner only
o_repeat  out  N_BTN  one-cycle auto-repeat pulse, owner only
o_busy  out  1  hold timer owned (FSM not IDLE)
o_owner  out  3  index of current timer owner; valid when o_busy=1

Behaviour:
- Reset is asynchronous, active-low, with clock i_clk. Reset values: o_level all 1; all pulse outputs 0; o_busy 0; o_owner 0; all counters 0; FSM IDLE. Reset mid-hold aborts with no pulse emitted.
- All outputs are registered. Limits are read live every cycle, never latched.
- Per-button debouncer, independent for each k:
  - Counter c[k] increments on each edge where i_btn[k] != o_level[k].
  - If i_btn[k] == o_level[k], c[k] clears.
  - When the mismatch is seen with c[k] >= L_D, o_level[k] takes i_btn[k] and c[k] clears.
  - Result: the level flips on the (L_D+1)-th consecutive mismatched edge. L_D = 0 means a flip on the first mismatched edge.
  - Using >= means lowering L_D mid-count never causes a wrap. c[k] saturates at all-ones.
- o_press[k] / o_release[k] are high exactly in the first cycle o_level[k] shows the new value. A single glitch shorter than L_D+1 cycles produces no event.
- Hold FSM, one shared timer T:
  - IDLE:
    - If L_L != 0 and any o_press bit is high, grant the lowest index k among them.
    - Set owner = k, T = 0, go to HOLD.
    - Simultaneous presses: only the lowest index is granted. The others still emit o_press but never get long/repeat for that press.
    - Presses while not IDLE are not queued.
  - HOLD:
    - T increments each cycle.
    - If o_level[owner] = 1, go to IDLE with no long pulse.
    - Otherwise, when the elapsed time reaches L_L, pulse o_long[owner], clear T, go to REPEAT.
    - Timing requirement: if o_press[k] is at cycle t, o_long[k] is at cycle t+L_L, provided o_level[k] stays 0 through t+L_L-1.
  - REPEAT:
    - If o_level[owner] = 1, go to IDLE.
    - If R != 0, pulse o_repeat[owner] at t+L_L+R, t+L_L+2R, and so on.
    - If R = 0, emit no pulses and stay until release.
    - Release and a due repeat in the same cycle: release wins, no pulse.
  - Config changes: L_L set to 0 while in HOLD/REPEAT returns the FSM to IDLE next cycle. R changed mid-period compares T against the new value (>=, no wrap).
- o_busy = (state != IDLE). o_owner holds the last owner while IDLE.
- At most one bit of o_long | o_repeat is set in any cycle.

Test Plan:
- Reset/idle: hold i_reset=0 with i_btn=4'b0000 -> o_level=4'b1111, all pulses 0, o_busy=0. Release reset with L_D=3 -> o_level[k] falls on the 4th edge, o_press=4'b1111 for one cycle.
- Glitch rejection: L_D=5; i_btn[1] low for 5 cycles then high -> no o_press[1], c[1] back to 0. Low for 6 cycles -> o_press[1] once, o_level[1]=0.
- Long + repeat: L_D=2, L_L=20, R=8; hold btn2 for 60 cycles after o_press at t -> o_long[2] at t+20, o_repeat[2] at t+28, t+36, t+44, ... until release. o_release[2] follows the debounced release and the FSM returns to IDLE.
- Short press: L_L=20; btn0 debounced low for 19 cycles -> no o_long, o_busy falls after release.
- Arbitration: btn1 and btn3 pressed in the same cycle, L_L=10 -> o_owner=1, o_long[1] only, o_press=4'b1010. Press btn0 while busy -> o_press[0] only, owner stays 1.
- Disable / mid-change: L_L=0 -> o_busy never asserts. In REPEAT, set R=0 -> repeats stop. Assert reset during REPEAT -> all outputs return to reset values immediately.
